// File: rtl/mmio_console.sv
// Memory-mapped console: 4-word register window on the CPU SRAM-style bus,
// TX byte FIFO drained over valid/ready, 1-deep RX holding register, level irq.
module mmio_console #(
  parameter logic [15:0] BASE_ADDR  = 16'hFFF0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic        notCS,
  input  logic        notOE,
  input  logic        notWE,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_wr_prev;
  logic          r_rd_prev;
  logic [7:0]    r_rx_byte;
  logic          r_rx_full;
  logic          r_rx_ovr;
  logic          r_tx_ovf;
  logic          r_rx_irq_en;
  logic          r_txe_irq_en;

  logic          w_hit;
  logic [1:0]    w_sel;
  logic          w_wr_now;
  logic          w_strobe;
  logic          w_rd_now;
  logic          w_rx_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_unused_data;

  // Bus decode and edge detection of write/read pulses
  assign w_hit      = !notCS && (addr[15:2] == BASE_ADDR[15:2]);
  assign w_sel      = addr[1:0];
  assign w_wr_now   = w_hit && !notWE;
  assign w_strobe   = w_wr_now && !r_wr_prev;
  assign data_oe    = w_hit && !notOE && notWE;
  assign w_rd_now   = data_oe && (w_sel == 2'd0);
  assign w_rx_pop   = r_rd_prev && !w_rd_now;

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == CW'(0));
  assign w_pop      = tx_valid && tx_ready;
  assign w_push_req = w_strobe && (w_sel == 2'd0);
  // A full FIFO still accepts a push when a pop frees a slot on the same edge
  assign w_push     = w_push_req && (!w_full || w_pop);

  assign tx_valid   = !w_empty;
  assign tx_data    = r_mem[r_rd_ptr];
  assign irq        = (r_rx_irq_en && r_rx_full) || (r_txe_irq_en && w_empty);

  assign w_unused_data = ^data_in[15:8];

  always_comb begin
    data_out = 16'h0000;
    if (data_oe) begin
      case (w_sel)
        2'd0:    data_out = {r_rx_full, 7'b0, r_rx_byte};
        2'd1:    data_out = {8'(r_count), 3'b0, r_tx_ovf, r_rx_ovr, r_rx_full,
                             w_empty, w_full};
        2'd2:    data_out = {14'b0, r_txe_irq_en, r_rx_irq_en};
        default: data_out = 16'h0000;
      endcase
    end
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= AW'(r_wr_ptr + AW'(1));
      if (w_pop)  r_rd_ptr <= AW'(r_rd_ptr + AW'(1));
      r_count <= CW'(r_count + CW'(w_push) - CW'(w_pop));
    end
  end

  // wr_prev resets high so a write pulse held across reset release is ignored
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_prev <= 1'b1;
      r_rd_prev <= 1'b0;
    end else begin
      r_wr_prev <= w_wr_now;
      r_rd_prev <= w_rd_now;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_byte    <= '0;
      r_rx_full    <= 1'b0;
      r_rx_ovr     <= 1'b0;
      r_tx_ovf     <= 1'b0;
      r_rx_irq_en  <= 1'b0;
      r_txe_irq_en <= 1'b0;
    end else begin
      if (w_strobe && (w_sel == 2'd1)) begin
        if (data_in[3]) r_rx_ovr <= 1'b0;
        if (data_in[4]) r_tx_ovf <= 1'b0;
      end
      if (w_strobe && (w_sel == 2'd2)) begin
        r_rx_irq_en  <= data_in[0];
        r_txe_irq_en <= data_in[1];
      end
      if (w_push_req && w_full && !w_pop) r_tx_ovf <= 1'b1;
      // New byte always lands; overrun only if the old one was never popped
      if (rx_valid) begin
        r_rx_byte <= rx_data;
        r_rx_full <= 1'b1;
        if (r_rx_full && !w_rx_pop) r_rx_ovr <= 1'b1;
      end else if (w_rx_pop) begin
        r_rx_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// Scoreboard bench for mmio_console: expected TX bytes queued at write time,
// popped and compared as the stream sink accepts them.
module tb_mmio_console;

  localparam int unsigned DEPTH = 8;
  localparam logic [15:0] BASE  = 16'hFFF0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] data_out;
  logic        data_oe;
  logic        notCS = 1'b1;
  logic        notOE = 1'b1;
  logic        notWE = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        irq;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  q[$];
  int          push_req = 0;
  int          push_ack = 0;
  logic [7:0]  pend_byte = 8'h00;
  int          ovf_events = 0;
  int          ovf_clr_mark = 0;
  bit          mon_pop;

  mmio_console #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .addr(addr), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .notCS(notCS), .notOE(notOE),
    .notWE(notWE), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_status(input bit rxf, input bit rxo);
    int n;
    n = q.size();
    return {8'(n), 3'b0, (ovf_events != ovf_clr_mark), rxo, rxf, (n == 0), (n == DEPTH)};
  endfunction

  // Mid-cycle model of the TX path: check, then apply what the next edge does
  always @(negedge clock) begin
    if (!reset) begin
      chk("tx_valid", 16'(tx_valid), 16'(q.size() != 0));
      mon_pop = tx_ready && (q.size() != 0);
      if (mon_pop) chk("tx_data", 16'(tx_data), 16'(q[0]));
      if (push_req != push_ack) begin
        if (q.size() < DEPTH || mon_pop) q.push_back(pend_byte);
        else ovf_events++;
        push_ack++;
      end
      if (mon_pop) void'(q.pop_front());
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d, input int n, input bit rdy);
    @(posedge clock); #1;
    addr = a; data_in = d; notCS = 1'b0; notWE = 1'b0; tx_ready = rdy;
    if (a == BASE) begin
      pend_byte = d[7:0];
      push_req++;
    end
    repeat (n) @(posedge clock);
    #1;
    notCS = 1'b1; notWE = 1'b1; tx_ready = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input int n, input string tag, input logic [15:0] exp);
    @(posedge clock); #1;
    addr = a; notCS = 1'b0; notOE = 1'b0;
    repeat (n) begin
      @(negedge clock);
      chk({tag, "_oe"}, 16'(data_oe), 16'd1);
      chk(tag, data_out, exp);
    end
    @(posedge clock); #1;
    notCS = 1'b1; notOE = 1'b1;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(posedge clock); #1;
    rx_valid = 1'b1; rx_data = d;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    @(posedge clock); #1;
    tx_ready = 1'b1;
    while (q.size() != 0 && k < 40) begin
      @(negedge clock); #1;
      k++;
    end
    chk("drain_done", 16'(q.size() == 0), 16'd1);
    @(posedge clock); #1;
    tx_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_irq", 16'(irq), 16'd0);
    chk("rst_oe", 16'(data_oe), 16'd0);
    chk("rst_dout", data_out, 16'h0000);
    cpu_read(BASE + 16'd1, 1, "rst_status", 16'h0002);

    // Long write pulse yields exactly one push
    cpu_write(BASE, 16'h1241, 3, 1'b0);
    cpu_read(BASE + 16'd1, 1, "st_one", exp_status(1'b0, 1'b0));
    cpu_read(BASE + 16'd1, 1, "st_one_k", 16'h0100);
    drain();

    // Overflow on the ninth byte, then stream out
    for (int i = 1; i <= 9; i++) cpu_write(BASE, 16'(i), 1, 1'b0);
    cpu_read(BASE + 16'd1, 1, "st_ovf", exp_status(1'b0, 1'b0));
    cpu_read(BASE + 16'd1, 1, "st_ovf_k", 16'h0811);
    drain();
    cpu_read(BASE + 16'd1, 1, "st_drained", 16'h0012);

    // Clear tx_ovf, fill, then push on the same edge as a pop
    cpu_write(BASE + 16'd1, 16'h0010, 1, 1'b0);
    ovf_clr_mark = ovf_events;
    cpu_read(BASE + 16'd1, 1, "st_w1c", 16'h0002);
    for (int i = 0; i < 8; i++) cpu_write(BASE, 16'(8'hA0 + i), 1, 1'b0);
    cpu_write(BASE, 16'h00B0, 1, 1'b1);
    cpu_read(BASE + 16'd1, 1, "st_simul", exp_status(1'b0, 1'b0));
    cpu_read(BASE + 16'd1, 1, "st_simul_k", 16'h0801);
    drain();

    // RX single byte, popped on the trailing edge of the read
    rx_pulse(8'h5A);
    cpu_read(BASE, 2, "rx_data", 16'h805A);
    cpu_read(BASE + 16'd1, 1, "st_rx_pop", 16'h0002);

    // RX overrun and its W1C
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    cpu_read(BASE + 16'd1, 1, "st_rx_ovr", exp_status(1'b1, 1'b1));
    cpu_read(BASE, 1, "rx_over", 16'h8022);
    cpu_read(BASE + 16'd1, 1, "st_rx_ovr2", 16'h000A);
    cpu_write(BASE + 16'd1, 16'h0008, 1, 1'b0);
    cpu_read(BASE + 16'd1, 1, "st_ovr_clr", 16'h0002);

    // Write wins over a concurrent read; sel 3 reads zero
    @(posedge clock); #1;
    addr = BASE + 16'd3; notCS = 1'b0; notOE = 1'b0; notWE = 1'b0;
    @(negedge clock);
    chk("rw_oe", 16'(data_oe), 16'd0);
    chk("rw_dout", data_out, 16'h0000);
    @(posedge clock); #1;
    notCS = 1'b1; notOE = 1'b1; notWE = 1'b1;
    cpu_read(BASE + 16'd3, 1, "sel3", 16'h0000);

    // CTRL and irq
    cpu_write(BASE + 16'd2, 16'hFFFF, 1, 1'b0);
    @(negedge clock);
    chk("irq_txe", 16'(irq), 16'd1);
    cpu_read(BASE + 16'd2, 1, "ctrl", 16'h0003);

    // Reset with a write pulse held across deassert
    @(posedge clock); #1;
    addr = BASE; data_in = 16'h0077; notCS = 1'b0; notWE = 1'b0; reset = 1'b1;
    ovf_clr_mark = ovf_events;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    notCS = 1'b1; notWE = 1'b1;
    @(negedge clock);
    chk("post_rst_irq", 16'(irq), 16'd0);
    chk("post_rst_valid", 16'(tx_valid), 16'd0);
    cpu_read(BASE + 16'd1, 1, "post_rst_st", 16'h0002);
    cpu_read(BASE + 16'd2, 1, "post_rst_ctrl", 16'h0000);

    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
